// File: rtl/spi_apb_sequencer_pkg.sv
// Shared types for the SPI APB sequencer: register offsets, step and FSM
// encodings, and helpers that map a step to its APB address offset and direction.
package spi_apb_pkg;

  localparam logic [3:0] OFF_CONFIG = 4'd0;
  localparam logic [3:0] OFF_TX     = 4'd1;
  localparam logic [3:0] OFF_STATE  = 4'd0;
  localparam logic [3:0] OFF_RX     = 4'd1;
  localparam logic [3:0] OFF_CMD    = 4'd3;

  typedef enum logic [2:0] {
    CFG  = 3'd0,
    TX   = 3'd1,
    CMD  = 3'd2,
    POLL = 3'd3,
    RX   = 3'd4
  } step_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } top_state_t;

  typedef enum logic [1:0] {
    X_IDLE   = 2'd0,
    X_SETUP  = 2'd1,
    X_ACCESS = 2'd2
  } xfer_state_t;

  // Register offset (PADDR[5:2]) addressed by each step.
  function automatic logic [3:0] step_offset(step_t s);
    case (s)
      CFG:     return OFF_CONFIG;
      TX:      return OFF_TX;
      CMD:     return OFF_CMD;
      POLL:    return OFF_STATE;
      RX:      return OFF_RX;
      default: return OFF_CONFIG;
    endcase
  endfunction

  // CONFIG, TX and CMD are writes; STATE and RX are reads.
  function automatic logic step_is_write(step_t s);
    return (s == CFG) || (s == TX) || (s == CMD);
  endfunction

endpackage

// File: rtl/spi_apb_sequencer_if.sv
// APB bus between the sequencer (master) and the SPI peripheral's APB slave.
interface spi_apb_sequencer_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [15:0] paddr;
  logic [7:0]  pwdata;
  logic [7:0]  prdata;
  logic        pready;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready
  );
endinterface

// File: rtl/spi_apb_sequencer_xfer.sv
// Single-transfer APB master. A start presented while idle, or in the same
// cycle as an ack, launches the next SETUP immediately so PSEL stays high
// across a chain of transfers.
module apb_xfer_engine
  import spi_apb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic        write,
  output logic [7:0]  rdata,
  output logic        ack,
  spi_apb_sequencer_if.master bus
);

  xfer_state_t state_q, state_d;
  logic        load;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic        write_q;

  // Next-state logic: SETUP always lasts one cycle, ACCESS waits for PREADY.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    ack     = (state_q == X_ACCESS) && bus.pready;
    case (state_q)
      X_IDLE: begin
        if (start) begin
          state_d = X_SETUP;
          load    = 1'b1;
        end
      end
      X_SETUP: state_d = X_ACCESS;
      X_ACCESS: begin
        if (bus.pready) begin
          if (start) begin
            state_d = X_SETUP;
            load    = 1'b1;
          end else begin
            state_d = X_IDLE;
          end
        end
      end
      default: state_d = X_IDLE;
    endcase
  end

  // Transfer state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= X_IDLE;
    else     state_q <= state_d;
  end

  // Address/data/direction are latched at launch and held through ACCESS.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else if (load) begin
      addr_q  <= addr;
      wdata_q <= wdata;
      write_q <= write;
    end
  end

  assign bus.psel    = (state_q != X_IDLE);
  assign bus.penable = (state_q == X_ACCESS);
  assign bus.pwrite  = write_q;
  assign bus.paddr   = addr_q;
  assign bus.pwdata  = wdata_q;
  assign rdata       = bus.prdata;

endmodule

// File: rtl/spi_apb_sequencer.sv
// Per-request SPI byte exchange over APB: optional CONFIG write (skipped when
// the cached value matches), TX write, CMD start, STATE polling bounded by
// POLL_MAX, then RX read. Result is reported by a done or timeout pulse.
module spi_apb_sequencer
  import spi_apb_pkg::*;
#(
  parameter logic [9:0] BASE_ADDR = 10'h001,
  parameter int         BUSY_BIT  = 0,
  parameter logic [7:0] CMD_START = 8'h01,
  parameter int         POLL_MAX  = 255
) (
  input  logic       i_PCLK,
  input  logic       i_PRESET,
  input  logic       i_req,
  input  logic [7:0] i_tx_byte,
  input  logic [7:0] i_cfg,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_timeout,
  output logic [7:0] o_rx_byte,
  spi_apb_sequencer_if.master apb
);

  localparam logic [7:0] POLL_LAST = 8'(POLL_MAX - 1);

  top_state_t state_q, state_d;
  step_t      step_q, step_d;
  logic [7:0] poll_cnt_q;
  logic [7:0] cfg_q, tx_q;
  logic       cfg_valid_q;
  logic [7:0] cfg_last_q;
  logic [7:0] rx_q;
  logic       busy_q, done_q, timeout_q;

  logic       accept, start, go_done, go_timeout, poll_inc, cfg_commit, rx_load;
  logic [7:0] cfg_src, tx_src;
  logic [7:0] req_wdata;
  logic [15:0] req_addr;
  logic        req_write;
  logic [7:0]  rdata;
  logic        ack;

  apb_xfer_engine u_xfer (
    .clk   (i_PCLK),
    .rst   (i_PRESET),
    .start (start),
    .addr  (req_addr),
    .wdata (req_wdata),
    .write (req_write),
    .rdata (rdata),
    .ack   (ack),
    .bus   (apb)
  );

  // Step sequencing: each ack chains straight into the next step's launch.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    accept     = 1'b0;
    start      = 1'b0;
    go_done    = 1'b0;
    go_timeout = 1'b0;
    poll_inc   = 1'b0;
    cfg_commit = 1'b0;
    rx_load    = 1'b0;
    // The first step launches in the acceptance cycle, before capture lands.
    cfg_src    = (state_q == IDLE) ? i_cfg : cfg_q;
    tx_src     = (state_q == IDLE) ? i_tx_byte : tx_q;
    case (state_q)
      IDLE: begin
        if (i_req) begin
          accept  = 1'b1;
          start   = 1'b1;
          step_d  = (cfg_valid_q && (i_cfg == cfg_last_q)) ? TX : CFG;
          state_d = RUN;
        end
      end
      RUN: begin
        if (ack) begin
          case (step_q)
            CFG: begin
              cfg_commit = 1'b1;
              start      = 1'b1;
              step_d     = TX;
            end
            TX: begin
              start  = 1'b1;
              step_d = CMD;
            end
            CMD: begin
              start  = 1'b1;
              step_d = POLL;
            end
            POLL: begin
              if (!rdata[BUSY_BIT]) begin
                start  = 1'b1;
                step_d = RX;
              end else if (poll_cnt_q == POLL_LAST) begin
                go_timeout = 1'b1;
                state_d    = DONE;
              end else begin
                poll_inc = 1'b1;
                start    = 1'b1;
              end
            end
            RX: begin
              rx_load = 1'b1;
              go_done = 1'b1;
              state_d = DONE;
            end
            default: state_d = IDLE;
          endcase
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    req_write = step_is_write(step_d);
    req_addr  = {BASE_ADDR, step_offset(step_d), 2'b00};
    case (step_d)
      CFG:     req_wdata = cfg_src;
      TX:      req_wdata = tx_src;
      CMD:     req_wdata = CMD_START;
      default: req_wdata = 8'h00;
    endcase
  end

  // Top FSM state register.
  always_ff @(posedge i_PCLK) begin
    if (i_PRESET) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Request capture, poll counter, CONFIG cache and client-facing outputs.
  always_ff @(posedge i_PCLK) begin
    if (i_PRESET) begin
      step_q      <= CFG;
      poll_cnt_q  <= 8'h00;
      cfg_q       <= 8'h00;
      tx_q        <= 8'h00;
      cfg_valid_q <= 1'b0;
      cfg_last_q  <= 8'h00;
      rx_q        <= 8'h00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      step_q <= step_d;
      if (accept) begin
        cfg_q      <= i_cfg;
        tx_q       <= i_tx_byte;
        poll_cnt_q <= 8'h00;
      end else if (poll_inc) begin
        poll_cnt_q <= poll_cnt_q + 8'd1;
      end
      // A timed-out transfer leaves the peripheral state unknown, so force a rewrite.
      if (cfg_commit) begin
        cfg_valid_q <= 1'b1;
        cfg_last_q  <= cfg_q;
      end else if (go_timeout) begin
        cfg_valid_q <= 1'b0;
      end
      if (rx_load) rx_q <= rdata;
      if (accept)                      busy_q <= 1'b1;
      else if (go_done || go_timeout)  busy_q <= 1'b0;
      done_q    <= go_done;
      timeout_q <= go_timeout;
    end
  end

  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_timeout = timeout_q;
  assign o_rx_byte = rx_q;

endmodule

// File: tb/tb_spi_apb_sequencer.sv
// Scoreboard bench for spi_apb_sequencer: directed requests push the expected
// APB transfers and completion events; a negedge monitor pops and compares.
module tb_spi_apb_sequencer;
  import spi_apb_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic [7:0] tx, cfg;
  logic       busy, done, timeout;
  logic [7:0] rx_byte;

  spi_apb_sequencer_if bus ();

  spi_apb_sequencer #(.POLL_MAX(4)) dut (
    .i_PCLK    (clk),
    .i_PRESET  (rst),
    .i_req     (req),
    .i_tx_byte (tx),
    .i_cfg     (cfg),
    .o_busy    (busy),
    .o_done    (done),
    .o_timeout (timeout),
    .o_rx_byte (rx_byte),
    .apb       (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [1:0] kind;  // 0 APB transfer, 1 done, 2 timeout
    logic       wr;
    logic [3:0] off;
    logic [7:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  tests = 0;
  int  fails = 0;

  // Slave model controls
  int         busy_left    = 0;
  bit         busy_forever = 1'b0;
  bit         stall_en     = 1'b0;
  bit         hold_cmd     = 1'b0;
  int         stall_cnt    = 0;
  logic [7:0] rx_val       = 8'h00;

  wire [3:0] cur_off = bus.paddr[5:2];
  wire tx_stall  = stall_en && (stall_cnt < 5) && bus.psel && bus.penable &&
                   bus.pwrite && (cur_off == 4'd1);
  wire cmd_stall = hold_cmd && bus.psel && bus.penable && bus.pwrite && (cur_off == 4'd3);

  assign bus.pready = !(tx_stall || cmd_stall);
  assign bus.prdata = (cur_off == 4'd0) ? ((busy_forever || busy_left > 0) ? 8'h01 : 8'h00) :
                      (cur_off == 4'd1) ? rx_val : 8'h00;

  always @(posedge clk) begin
    if (bus.psel && bus.penable && bus.pready && !bus.pwrite && cur_off == 4'd0 &&
        !busy_forever && busy_left > 0)
      busy_left <= busy_left - 1;
    if (tx_stall) stall_cnt <= stall_cnt + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic ev_t mk_ev(input logic [1:0] k, input logic w, input logic [3:0] o,
                                input logic [7:0] d);
    ev_t e;
    e.kind = k; e.wr = w; e.off = o; e.data = d;
    return e;
  endfunction

  task automatic compare_ev(input ev_t got);
    ev_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: got %h expected none (cycle %0d)", got, cyc);
    end else begin
      e = exp_q.pop_front();
      if (got != e) begin
        fails++;
        $display("FAIL event: got %h expected %h (cycle %0d)", got, e, cyc);
      end
    end
  endtask

  task automatic push_w(input logic [3:0] o, input logic [7:0] d);
    exp_q.push_back(mk_ev(2'd0, 1'b1, o, d));
  endtask
  task automatic push_r(input logic [3:0] o, input logic [7:0] d);
    exp_q.push_back(mk_ev(2'd0, 1'b0, o, d));
  endtask

  // Monitor: signal stability through ACCESS, completed transfers, client pulses.
  logic [15:0] s_addr;
  logic [7:0]  s_wdata;
  logic        s_wr;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.psel && !bus.penable) begin
        s_addr  <= bus.paddr;
        s_wdata <= bus.pwdata;
        s_wr    <= bus.pwrite;
      end
      if (bus.psel && bus.penable) begin
        check("hold_paddr", bus.paddr, s_addr);
        check("hold_pwdata", bus.pwdata, s_wdata);
        check("hold_pwrite", bus.pwrite, s_wr);
      end
      if (bus.psel && bus.penable && bus.pready) begin
        check("paddr_base", bus.paddr[15:6], 10'h001);
        check("paddr_low", bus.paddr[1:0], 0);
        compare_ev(mk_ev(2'd0, bus.pwrite, cur_off, bus.pwrite ? bus.pwdata : bus.prdata));
      end
      if (done)    compare_ev(mk_ev(2'd1, 1'b0, 4'd0, rx_byte));
      if (timeout) compare_ev(mk_ev(2'd2, 1'b0, 4'd0, rx_byte));
      if (done || timeout) check("done_timeout_exclusive", done && timeout, 0);
    end
  end

  task automatic wait_end(output int at, output int was_to);
    at = -1; was_to = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done || timeout) begin
        at = cyc; was_to = timeout ? 1 : 0;
        return;
      end
    end
    check("wait_end_bound", 0, 1);
  endtask

  task automatic run_req(input logic [7:0] c, input logic [7:0] t, input int lat, input int exp_to);
    int acc, at, to;
    @(negedge clk);
    cfg = c; tx = t; req = 1'b1; acc = cyc;
    @(negedge clk);
    req = 1'b0;
    check("busy_after_accept", busy, 1);
    wait_end(at, to);
    check("latency", at - acc, lat);
    check("end_kind_timeout", to, exp_to);
    check("busy_at_end", busy, 0);
  endtask

  initial begin
    int acc, acc2, at, to;
    bit found;
    rst = 1'b1; req = 1'b0; cfg = 8'h00; tx = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_rx_byte", rx_byte, 0);
    check("rst_psel", bus.psel, 0);
    check("rst_penable", bus.penable, 0);
    check("rst_paddr", bus.paddr, 0);
    check("rst_pwdata", bus.pwdata, 0);
    rst = 1'b0;

    // First request: CONFIG written, 11-cycle latency
    rx_val = 8'h5A;
    push_w(0, 8'h3C); push_w(1, 8'hA5); push_w(3, 8'h01); push_r(0, 8'h00); push_r(1, 8'h5A);
    exp_q.push_back(mk_ev(2'd1, 1'b0, 4'd0, 8'h5A));
    run_req(8'h3C, 8'hA5, 11, 0);

    // Same CONFIG: skipped, 9-cycle latency
    rx_val = 8'h22;
    push_w(1, 8'h11); push_w(3, 8'h01); push_r(0, 8'h00); push_r(1, 8'h22);
    exp_q.push_back(mk_ev(2'd1, 1'b0, 4'd0, 8'h22));
    run_req(8'h3C, 8'h11, 9, 0);

    // Changed CONFIG: rewritten before TX
    rx_val = 8'h44;
    push_w(0, 8'h3D); push_w(1, 8'h33); push_w(3, 8'h01); push_r(0, 8'h00); push_r(1, 8'h44);
    exp_q.push_back(mk_ev(2'd1, 1'b0, 4'd0, 8'h44));
    run_req(8'h3D, 8'h33, 11, 0);

    // Busy for three STATE reads, then free
    busy_left = 3; rx_val = 8'h66;
    push_w(1, 8'h55); push_w(3, 8'h01);
    push_r(0, 8'h01); push_r(0, 8'h01); push_r(0, 8'h01); push_r(0, 8'h00); push_r(1, 8'h66);
    exp_q.push_back(mk_ev(2'd1, 1'b0, 4'd0, 8'h66));
    run_req(8'h3D, 8'h55, 15, 0);

    // Always busy: four polls then timeout, rx byte unchanged
    busy_forever = 1'b1;
    push_w(1, 8'h77); push_w(3, 8'h01);
    push_r(0, 8'h01); push_r(0, 8'h01); push_r(0, 8'h01); push_r(0, 8'h01);
    exp_q.push_back(mk_ev(2'd2, 1'b0, 4'd0, 8'h66));
    run_req(8'h3D, 8'h77, 13, 1);
    check("psel_at_timeout", bus.psel, 0);
    busy_forever = 1'b0;

    // After timeout the same CONFIG is written again
    rx_val = 8'h99;
    push_w(0, 8'h3D); push_w(1, 8'h88); push_w(3, 8'h01); push_r(0, 8'h00); push_r(1, 8'h99);
    exp_q.push_back(mk_ev(2'd1, 1'b0, 4'd0, 8'h99));
    run_req(8'h3D, 8'h88, 11, 0);

    // PREADY low for five cycles in TX ACCESS
    stall_en = 1'b1; stall_cnt = 0; rx_val = 8'hBC;
    push_w(1, 8'h9A); push_w(3, 8'h01); push_r(0, 8'h00); push_r(1, 8'hBC);
    exp_q.push_back(mk_ev(2'd1, 1'b0, 4'd0, 8'hBC));
    run_req(8'h3D, 8'h9A, 14, 0);
    check("tx_stall_cycles", stall_cnt, 5);
    stall_en = 1'b0;

    // Reset during CMD ACCESS
    hold_cmd = 1'b1;
    push_w(1, 8'hC1);
    @(negedge clk);
    cfg = 8'h3D; tx = 8'hC1; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.psel && bus.penable && cur_off == 4'd3) found = 1'b1;
    end
    check("reach_cmd_access", found, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_psel", bus.psel, 0);
    check("rst_mid_penable", bus.penable, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    rst = 1'b0; hold_cmd = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("after_rst_no_done", done, 0);
    end

    // req held high: back-to-back, CONFIG rewritten after reset
    rx_val = 8'hE1;
    push_w(0, 8'h3D); push_w(1, 8'hD1); push_w(3, 8'h01); push_r(0, 8'h00); push_r(1, 8'hE1);
    exp_q.push_back(mk_ev(2'd1, 1'b0, 4'd0, 8'hE1));
    push_w(1, 8'hD1); push_w(3, 8'h01); push_r(0, 8'h00); push_r(1, 8'hE1);
    exp_q.push_back(mk_ev(2'd1, 1'b0, 4'd0, 8'hE1));
    @(negedge clk);
    cfg = 8'h3D; tx = 8'hD1; req = 1'b1; acc = cyc;
    wait_end(at, to);
    check("b2b_first_latency", at - acc, 11);
    @(negedge clk);
    acc2 = cyc;
    check("b2b_idle_gap_busy", busy, 0);
    @(negedge clk);
    check("b2b_second_busy", busy, 1);
    req = 1'b0;
    wait_end(at, to);
    check("b2b_second_latency", at - acc2, 9);
    check("b2b_second_kind", to, 0);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
